// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control path: FSM states,
// opcode values, datapath select encodings and the post-decode state lookup.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_TRAP
    } state_e;

    // Class of ALU operation requested by the FSM; FUNCT defers to funct3/funct7.
    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT
    } aluop_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // State following DECODE for a given opcode; unknown opcodes either park
    // in TRAP or fall back to FETCH as a NOP.
    function automatic state_e decode_next(input logic [6:0] op, input logic trap_on_illegal);
        case (op)
            OP_LOAD, OP_STORE: return S_MEMADR;
            OP_RTYPE:          return S_EXECR;
            OP_ITYPE:          return S_EXECI;
            OP_BRANCH:         return S_BRANCH;
            OP_JAL:            return S_JAL;
            default:           return trap_on_illegal ? S_TRAP : S_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decoder: maps the FSM's ALU operation class and
// the instruction's funct3/funct7b5/op[5] fields onto the 4-bit ALUControl.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  aluop_e     aluop,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [3:0] alu_control
);

    // Select the ALU operation; op5 separates R-type (SUB possible) from addi.
    always_comb begin
        // NOTE: a default ahead of the case keeps every path assigned, so no latch is inferred.
        alu_control = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I datapath. Sequences fetch,
// decode, address generation, execute, memory access and write-back over the
// shared ALU and unified memory port, stalling on MemReady.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter bit          RESET_STATE_TRAP = 1'b0,
    parameter int unsigned MEM_TIMEOUT      = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       Illegal
);

    localparam int unsigned     CNT_W        = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_e           state;
    logic             jal_path;
    logic [CNT_W-1:0] wait_cnt;
    aluop_e           aluop;
    logic [3:0]       alu_ctrl;
    logic             mem_state;
    logic             timeout_hit;
    logic             branch_legal;
    logic             branch_taken;

    alu_decoder u_alu_decoder (
        .aluop       (aluop),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (alu_ctrl)
    );

    // States that hold a memory request open and may stall on MemReady.
    assign mem_state    = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    // Fires on the wait cycle that would bring the stall count to MEM_TIMEOUT.
    assign timeout_hit  = (MEM_TIMEOUT != 0) && mem_state && !MemReady && (wait_cnt == TIMEOUT_LAST);
    assign branch_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
    assign branch_taken = (funct3 == 3'b000) ? Zero :
                          (funct3 == 3'b001) ? ~Zero : 1'b0;

    // State register, JAL-path flag and memory stall counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // Reset wins over everything, including a MemReady arriving mid-access.
            state    <= S_FETCH;
            wait_cnt <= '0;
            jal_path <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (mem_state && !MemReady) wait_cnt <= wait_cnt + 1'b1;
            else                        wait_cnt <= '0;

            case (state)
                S_FETCH: begin
                    if (timeout_hit)   state <= S_TRAP;
                    else if (MemReady) state <= S_DECODE;
                end
                S_DECODE:  state <= decode_next(op, RESET_STATE_TRAP);
                S_MEMADR:  state <= op[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD: begin
                    if (timeout_hit)   state <= S_TRAP;
                    else if (MemReady) state <= S_MEMWB;
                end
                S_MEMWB:   state <= S_FETCH;
                S_MEMWRITE: begin
                    if (timeout_hit)   state <= S_TRAP;
                    else if (MemReady) state <= S_FETCH;
                end
                S_EXECR, S_EXECI: state <= S_ALUWB;
                S_ALUWB: begin
                    state    <= S_FETCH;
                    jal_path <= 1'b0;
                end
                S_BRANCH: begin
                    if (!branch_legal && RESET_STATE_TRAP) state <= S_TRAP;
                    else                                   state <= S_FETCH;
                end
                S_JAL: begin
                    state    <= S_ALUWB;
                    jal_path <= 1'b1;
                end
                S_TRAP:  state <= S_TRAP;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Moore decode of the datapath controls; everything is forced low while reset is held.
    always_comb begin
        MemReq    = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ImmSrc    = IMM_I;
        Illegal   = 1'b0;
        aluop     = ALUOP_ADD;

        case (state)
            S_FETCH: begin
                MemReq    = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_B;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = op[5] ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                MemReq   = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                aluop   = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                if (jal_path) begin
                    // Link value OldPC+4 is recomputed this cycle and taken straight from the ALU.
                    ALUSrcA   = SRCA_OLDPC;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURESULT;
                end
            end
            S_BRANCH: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                aluop   = ALUOP_SUB;
                PCWrite = branch_taken;
            end
            S_JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
            end
            S_TRAP:  Illegal = 1'b1;
            default: Illegal = 1'b0;
        endcase

        ALUControl = alu_ctrl;

        if (!reset) begin
            MemReq     = 1'b0;
            MemWrite   = 1'b0;
            AdrSrc     = 1'b0;
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            RegWrite   = 1'b0;
            ResultSrc  = 2'b00;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b00;
            ImmSrc     = 2'b00;
            ALUControl = 4'b0000;
            Illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: each step drives inputs, pushes
// the expected control vector onto a scoreboard and compares once settled.
module tb_multicycle_controller;

    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_RTYPE  = 7'b0110011;
    localparam logic [6:0] T_ITYPE  = 7'b0010011;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_JAL    = 7'b1101111;
    localparam logic [6:0] T_BAD    = 7'b1111111;

    typedef enum {
        T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
        T_EXECR, T_EXECI, T_ALUWB, T_BRBR, T_JALS, T_TRAP
    } tb_st_e;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic [3:0] alu_control;
        logic       illegal;
    } ctrl_t;

    typedef struct {
        string tag;
        ctrl_t exp;
    } sb_t;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [3:0] alu;
    } ex_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;
    logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [3:0] ALUControl;
    ctrl_t      obs;

    sb_t sb_q[$];
    int  checks   = 0;
    int  failures = 0;

    always #5 clk = ~clk;

    multicycle_controller #(
        .RESET_STATE_TRAP (1'b1),
        .MEM_TIMEOUT      (6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .MemReq     (MemReq),
        .MemWrite   (MemWrite),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .Illegal    (Illegal)
    );

    assign obs = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal};

    // Expected controls for a state, from the control table and current inputs.
    function automatic ctrl_t ref_out(tb_st_e st, logic [3:0] alu, bit jalp);
        ctrl_t c;
        c = '0;
        if (!reset) return c;
        case (st)
            T_FETCH: begin
                c.mem_req = 1'b1; c.ir_write = MemReady; c.pc_write = MemReady;
                c.alu_src_b = 2'b10; c.result_src = 2'b10;
            end
            T_DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; c.imm_src = 2'b10; end
            T_MEMADR: begin
                c.alu_src_a = 2'b10; c.alu_src_b = 2'b01;
                c.imm_src = (op == T_STORE) ? 2'b01 : 2'b00;
            end
            T_MEMREAD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
            T_MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
            T_MEMWRITE: begin c.mem_req = 1'b1; c.mem_write = 1'b1; c.adr_src = 1'b1; end
            T_EXECR:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b00; c.alu_control = alu; end
            T_EXECI:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_control = alu; end
            T_ALUWB: begin
                c.reg_write = 1'b1;
                if (jalp) begin c.result_src = 2'b10; c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; end
            end
            T_BRBR: begin
                c.alu_src_a = 2'b10; c.alu_control = 4'b0001;
                c.pc_write = (funct3 == 3'b000) ? Zero : (funct3 == 3'b001) ? !Zero : 1'b0;
            end
            T_JALS:     begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_write = 1'b1; end
            T_TRAP:     c.illegal = 1'b1;
            default:    c = '0;
        endcase
        return c;
    endfunction

    // One cycle: queue the expectation, compare after settling, advance to next negedge.
    task automatic step(input string tag, input tb_st_e st, input logic [3:0] alu = 4'd0,
                        input bit jalp = 1'b0);
        sb_t e;
        e.tag = tag;
        e.exp = ref_out(st, alu, jalp);
        sb_q.push_back(e);
        #2;
        e = sb_q.pop_front();
        checks++;
        assert (obs === e.exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
        end
        @(negedge clk);
    endtask

    task automatic fetch_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                               input logic f7);
        op = o; funct3 = f3; funct7b5 = f7;
        MemReady = 1'b1;
        step({tag, "_fetch"}, T_FETCH);
        MemReady = 1'b0;
        step({tag, "_decode"}, T_DECODE);
    endtask

    ex_t ex_tab[12];

    initial begin
        ex_tab = '{
            '{T_RTYPE, 3'b000, 1'b1, 4'b0001},  // sub
            '{T_RTYPE, 3'b101, 1'b1, 4'b1000},  // sra
            '{T_ITYPE, 3'b101, 1'b0, 4'b0111},  // srli
            '{T_ITYPE, 3'b101, 1'b1, 4'b1000},  // srai
            '{T_ITYPE, 3'b000, 1'b1, 4'b0000},  // addi with imm bit 30 set
            '{T_RTYPE, 3'b000, 1'b0, 4'b0000},  // add
            '{T_ITYPE, 3'b011, 1'b0, 4'b1001},  // sltiu
            '{T_RTYPE, 3'b111, 1'b0, 4'b0010},  // and
            '{T_ITYPE, 3'b010, 1'b0, 4'b0101},  // slti
            '{T_RTYPE, 3'b001, 1'b0, 4'b0110},  // sll
            '{T_ITYPE, 3'b100, 1'b0, 4'b0100},  // xori
            '{T_RTYPE, 3'b110, 1'b0, 4'b0011}   // or
        };

        reset = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b0;
        @(negedge clk);
        step("reset_a", T_FETCH);
        step("reset_b", T_FETCH);
        reset = 1'b1;
        repeat (3) step("fetch_wait", T_FETCH);

        // addi x1,x0,5
        op = T_ITYPE; funct3 = 3'b000; funct7b5 = 1'b0;
        MemReady = 1'b1;
        step("fetch_ready", T_FETCH);
        MemReady = 1'b0;
        step("addi_decode", T_DECODE);
        step("addi_execi", T_EXECI, 4'b0000);
        step("addi_aluwb", T_ALUWB);

        // jal, then the next write-back must be back on ALUOut
        fetch_instr("jal", T_JAL, 3'b000, 1'b0);
        step("jal_jal", T_JALS);
        step("jal_aluwb", T_ALUWB, 4'd0, 1'b1);

        for (int i = 0; i < 12; i++) begin
            fetch_instr($sformatf("ex%0d", i), ex_tab[i].op, ex_tab[i].f3, ex_tab[i].f7);
            step($sformatf("ex%0d_exec", i), (ex_tab[i].op == T_RTYPE) ? T_EXECR : T_EXECI,
                 ex_tab[i].alu);
            step($sformatf("ex%0d_aluwb", i), T_ALUWB);
        end

        // lw with a 4-cycle memory stall
        fetch_instr("lw", T_LOAD, 3'b010, 1'b0);
        step("lw_memadr", T_MEMADR);
        repeat (4) step("lw_stall", T_MEMREAD);
        MemReady = 1'b1;
        step("lw_ready", T_MEMREAD);
        MemReady = 1'b0;
        step("lw_memwb", T_MEMWB);

        // sw completing immediately
        fetch_instr("sw", T_STORE, 3'b010, 1'b0);
        step("sw_memadr", T_MEMADR);
        MemReady = 1'b1;
        step("sw_write", T_MEMWRITE);
        MemReady = 1'b0;

        // branches
        fetch_instr("beq", T_BRANCH, 3'b000, 1'b0);
        Zero = 1'b1;
        step("beq_taken", T_BRBR);
        fetch_instr("bne", T_BRANCH, 3'b001, 1'b0);
        step("bne_zero", T_BRBR);
        fetch_instr("bne2", T_BRANCH, 3'b001, 1'b0);
        Zero = 1'b0;
        step("bne_nonzero", T_BRBR);

        // reset in the middle of a stalled store, then the stall timeout from FETCH
        fetch_instr("sw2", T_STORE, 3'b010, 1'b0);
        step("sw2_memadr", T_MEMADR);
        repeat (3) step("sw2_stall", T_MEMWRITE);
        reset = 1'b0;
        step("sw2_reset", T_FETCH);
        reset = 1'b1;
        repeat (6) step("timeout_wait", T_FETCH);
        step("timeout_trap", T_TRAP);
        MemReady = 1'b1;
        step("trap_ignores_ready", T_TRAP);
        reset = 1'b0;
        step("trap_reset", T_FETCH);
        reset = 1'b1;

        // illegal opcode parks in TRAP until reset
        fetch_instr("illegal", T_BAD, 3'b000, 1'b0);
        step("illegal_trap_a", T_TRAP);
        MemReady = 1'b1;
        step("illegal_trap_b", T_TRAP);
        MemReady = 1'b0;
        reset = 1'b0;
        step("illegal_reset", T_FETCH);
        reset = 1'b1;
        step("after_reset_fetch", T_FETCH);

        // unsupported branch funct3 is treated as illegal
        fetch_instr("blt", T_BRANCH, 3'b100, 1'b0);
        Zero = 1'b1;
        step("blt_branch", T_BRBR);
        step("blt_trap", T_TRAP);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before the directed sequence finished");
        $fatal(1);
    end

endmodule
